myo_spi_scheduler: RTL and testbench

MYO_SPI_SCHEDULER -- requirements
Module: myo_spi_scheduler

---
 rtl/myo_spi_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_myo_spi_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/myo_spi_scheduler.sv
// myo_spi_scheduler: polls a set of motors over one shared SPI bus, one
// transaction per enabled motor per frame, with per-transaction timeout,
// optional frame pacing and a debounced motor-power qualifier.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   IDLE       | waiting for enable, power_ok and a non-empty motor mask
//   SELECT     | pick lowest masked motor at or above the pointer
//   START      | pulse spi_start for the selected motor
//   WAIT_DONE  | wait for spi_done rising edge or timeout
//   LATCH      | pulse latch_strobe / pid_update_strobe for the motor
//   FRAME_WAIT | all motors served; hold until the frame period elapses
module myo_spi_scheduler #(
    parameter int NUMBER_OF_MOTORS   = 6,
    parameter int TIMEOUT_CYCLES     = 5000,
    parameter int POWER_DELAY_CYCLES = 100_000_000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [NUMBER_OF_MOTORS-1:0] motor_mask,
    input  logic [31:0]                 frame_period,
    input  logic                        power_sense_n,
    input  logic                        spi_done,
    output logic                        spi_start,
    output logic [7:0]                  motor,
    output logic [NUMBER_OF_MOTORS-1:0] ss_gate_n,
    output logic                        latch_strobe,
    output logic [7:0]                  pid_update,
    output logic                        pid_update_strobe,
    output logic [31:0]                 frame_count,
    output logic [31:0]                 actual_frame_cycles,
    output logic [15:0]                 timeout_count,
    output logic                        busy
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] SELECT     = 3'd1;
    localparam logic [2:0] START      = 3'd2;
    localparam logic [2:0] WAIT_DONE  = 3'd3;
    localparam logic [2:0] LATCH      = 3'd4;
    localparam logic [2:0] FRAME_WAIT = 3'd5;

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PWR_W = $clog2(POWER_DELAY_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(POWER_DELAY_CYCLES - 1);

    logic [2:0]       state;
    logic [7:0]       pointer;
    logic [TMO_W-1:0] tmo_cnt;
    logic [PWR_W-1:0] pwr_cnt;
    logic             power_ok;
    logic             spi_done_q;
    logic             done_rise;
    logic [31:0]      frame_timer;
    logic [31:0]      ft_sat;
    logic [32:0]      ft_inc;
    logic             period_hit;
    logic             found;
    logic [7:0]       found_idx;

    // Power-good debounce: requires an unbroken run of low power_sense_n samples.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pwr_cnt  <= '0;
            power_ok <= 1'b0;
        end else if (power_sense_n) begin
            pwr_cnt  <= '0;
            power_ok <= 1'b0;
        end else if (!power_ok) begin
            if (pwr_cnt == PWR_LAST) begin
                power_ok <= 1'b1;
            end else begin
                pwr_cnt <= pwr_cnt + 1'b1;
            end
        end
    end

    // Previous spi_done level; sampled every cycle so an edge seen during
    // START is consumed and cannot complete the new transaction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            spi_done_q <= 1'b0;
        end else begin
            spi_done_q <= spi_done;
        end
    end

    assign done_rise = spi_done & ~spi_done_q;

    // Lowest masked motor at or above the pointer (descending scan, lowest wins).
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int j = NUMBER_OF_MOTORS - 1; j >= 0; j--) begin
            if (motor_mask[j] && (8'(j) >= pointer)) begin
                found     = 1'b1;
                found_idx = 8'(j);
            end
        end
    end

    // Frame timer arithmetic, widened so the +1 never wraps.
    always_comb begin
        ft_inc     = {1'b0, frame_timer} + 33'd1;
        ft_sat     = (&frame_timer) ? frame_timer : ft_inc[31:0];
        period_hit = (frame_period == 32'd0) || (ft_inc >= {1'b0, frame_period});
    end

    // Sequencer: motor selection, timeout, frame pacing and statistics.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            pointer             <= '0;
            motor               <= '0;
            pid_update          <= '0;
            tmo_cnt             <= '0;
            frame_timer         <= '0;
            frame_count         <= '0;
            actual_frame_cycles <= '0;
            timeout_count       <= '0;
        end else if (!power_ok) begin
            state <= IDLE;
        end else begin
            if (state != IDLE) begin
                frame_timer <= ft_sat;
            end
            case (state)
                IDLE: begin
                    if (enable && (|motor_mask)) begin
                        pointer     <= '0;
                        frame_timer <= '0;
                        state       <= SELECT;
                    end
                end
                SELECT: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (found) begin
                        motor <= found_idx;
                        state <= START;
                    end else begin
                        state <= FRAME_WAIT;
                    end
                end
                START: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (done_rise) begin
                        pid_update <= motor;
                        state      <= LATCH;
                    end else if (tmo_cnt == TMO_LAST) begin
                        if (timeout_count != 16'hFFFF) begin
                            timeout_count <= timeout_count + 16'd1;
                        end
                        pointer <= motor + 8'd1;
                        state   <= SELECT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                LATCH: begin
                    pointer <= motor + 8'd1;
                    state   <= SELECT;
                end
                FRAME_WAIT: begin
                    if (period_hit) begin
                        actual_frame_cycles <= ft_inc[32] ? 32'hFFFF_FFFF : ft_inc[31:0];
                        frame_count         <= frame_count + 32'd1;
                        pointer             <= '0;
                        frame_timer         <= '0;
                        state               <= enable ? SELECT : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are state decodes, suppressed the moment power is lost.
    always_comb begin
        spi_start         = (state == START) && power_ok;
        latch_strobe      = (state == LATCH) && power_ok;
        pid_update_strobe = (state == LATCH) && power_ok;
        busy              = (state != IDLE);
    end

    // Per-motor active-low select, only while the bus is addressing that motor.
    always_comb begin
        ss_gate_n = '1;
        if (power_ok && ((state == START) || (state == WAIT_DONE))) begin
            for (int j = 0; j < NUMBER_OF_MOTORS; j++) begin
                if (motor == 8'(j)) begin
                    ss_gate_n[j] = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_myo_spi_scheduler.sv
// Bench for myo_spi_scheduler: transaction-level reference model (expected
// motor order queue, per-transaction response plan, frame lengths computed
// arithmetically from the plan) checked cycle by cycle.
module tb_myo_spi_scheduler;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [5:0]  motor_mask;
    logic [31:0] frame_period;
    logic        power_sense_n;
    logic        spi_done;
    logic        spi_start;
    logic [7:0]  motor;
    logic [5:0]  ss_gate_n;
    logic        latch_strobe;
    logic [7:0]  pid_update;
    logic        pid_update_strobe;
    logic [31:0] frame_count;
    logic [31:0] actual_frame_cycles;
    logic [15:0] timeout_count;
    logic        busy;

    myo_spi_scheduler #(
        .NUMBER_OF_MOTORS  (6),
        .TIMEOUT_CYCLES    (20),
        .POWER_DELAY_CYCLES(4)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .enable             (enable),
        .motor_mask         (motor_mask),
        .frame_period       (frame_period),
        .power_sense_n      (power_sense_n),
        .spi_done           (spi_done),
        .spi_start          (spi_start),
        .motor              (motor),
        .ss_gate_n          (ss_gate_n),
        .latch_strobe       (latch_strobe),
        .pid_update         (pid_update),
        .pid_update_strobe  (pid_update_strobe),
        .frame_count        (frame_count),
        .actual_frame_cycles(actual_frame_cycles),
        .timeout_count      (timeout_count),
        .busy               (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state. A response delay d in 1..15 means spi_done
    // rises d cycles after the START cycle; 0 means it rises in the START
    // cycle itself (must be ignored); 99 means it never rises.
    int exp_q[$];
    int d_q[$];
    int cur_m      = 0;
    int gs         = -1;
    int ge         = -1;
    int lat_cycle  = -1;
    int resp_cycle = -1;
    int busy_from  = 1;
    int busy_to    = 0;
    int exp_frames   = 0;
    int exp_timeouts = 0;
    int exp_actual   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive the responder after the edge, check everything at negedge.
    task automatic tick();
        int m;
        int d;
        logic [5:0] one;
        logic [5:0] exp_gate;
        one = 6'b000001;
        @(posedge clock);
        #1;
        cyc++;
        spi_done = (cyc == resp_cycle);
        @(negedge clock);
        if (spi_start === 1'b1) begin
            chk("start_queued", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                m = exp_q.pop_front();
                d = d_q.pop_front();
                chk("start_motor", 32'(motor), 32'(m));
                cur_m = m;
                gs    = cyc;
                if (d >= 1 && d <= 15) begin
                    resp_cycle = cyc + d;
                    lat_cycle  = cyc + d + 1;
                    ge         = cyc + d;
                end else begin
                    lat_cycle  = -1;
                    ge         = cyc + 20;
                    resp_cycle = (d == 0) ? cyc : -1;
                    if (d == 0) spi_done = 1'b1;
                end
            end
        end
        exp_gate = (cyc >= gs && cyc <= ge) ? ~(one << cur_m) : 6'h3F;
        chk("ss_gate_n", 32'(ss_gate_n), 32'(exp_gate));
        chk("latch_strobe", 32'(latch_strobe), 32'(cyc == lat_cycle));
        chk("pid_update_strobe", 32'(pid_update_strobe), 32'(cyc == lat_cycle));
        if (cyc == lat_cycle) begin
            chk("latch_motor", 32'(motor), 32'(cur_m));
            chk("pid_update", 32'(pid_update), 32'(cur_m));
        end
        chk("busy", 32'(busy), 32'(cyc >= busy_from && cyc <= busy_to));
    endtask

    task automatic end_checks(input string tag);
        chk({tag, "_frame_count"}, frame_count, 32'(exp_frames));
        chk({tag, "_actual_frame_cycles"}, actual_frame_cycles, 32'(exp_actual));
        chk({tag, "_timeout_count"}, 32'(timeout_count), 32'(exp_timeouts));
        chk({tag, "_queue_drained"}, 32'(exp_q.size()), 0);
    endtask

    // mode 0: every motor answers after 10 cycles; mode 2: motor 2 never
    // answers; otherwise random answers. extra = cycles IDLE must wait for power_ok.
    task automatic run_phase(input string tag, input logic [5:0] mask, input int period,
                             input int nframes, input int mode, input int extra);
        int total;
        int len;
        int d;
        int r;
        int e;
        motor_mask   = mask;
        frame_period = 32'(period);
        total = 0;
        for (int f = 0; f < nframes; f++) begin
            len = 2;
            for (int j = 0; j < 6; j++) begin
                if (mask[j]) begin
                    if (mode == 0) d = 10;
                    else if (mode == 2) d = (j == 2) ? 99 : 10;
                    else begin
                        r = int'($urandom_range(0, 9));
                        d = (r == 0) ? 0 : (r == 1) ? 99 : int'($urandom_range(1, 15));
                    end
                    exp_q.push_back(j);
                    d_q.push_back(d);
                    if (d >= 1 && d <= 15) len += d + 3;
                    else begin
                        len += 22;
                        exp_timeouts++;
                    end
                end
            end
            if (period > len) len = period;
            total += len;
            exp_actual = len;
        end
        enable    = 1'b1;
        busy_from = cyc + 1 + extra;
        e         = busy_from + total - 1;
        busy_to   = e;
        while (cyc < e) tick();
        enable = 1'b0;
        tick();
        tick();
        exp_frames += nframes;
        end_checks(tag);
    endtask

    task automatic wait_start(input string tag, input int m);
        int k;
        k = 0;
        while (!(gs == cyc && cur_m == m) && k < 400) begin
            tick();
            k++;
        end
        chk({tag, "_start_seen"}, 32'(gs == cyc && cur_m == m), 1);
    endtask

    initial begin
        int s;
        logic [5:0] rmask;
        int rper;
        reset         = 1'b1;
        enable        = 1'b0;
        motor_mask    = 6'h00;
        frame_period  = 32'd0;
        power_sense_n = 1'b0;
        spi_done      = 1'b0;

        tick();
        tick();
        chk("rst_frame_count", frame_count, 0);
        chk("rst_actual", actual_frame_cycles, 0);
        chk("rst_timeout_count", 32'(timeout_count), 0);
        chk("rst_motor", 32'(motor), 0);
        chk("rst_pid_update", 32'(pid_update), 0);
        chk("rst_spi_start", 32'(spi_start), 0);
        reset = 1'b0;

        // Power qualification after reset, then full mask free-running.
        run_phase("all_free", 6'h3F, 0, 2, 0, 4);
        chk("all_free_len80", actual_frame_cycles, 80);

        run_phase("sparse", 6'b100101, 0, 2, 0, 0);
        run_phase("timeout", 6'h3F, 0, 1, 2, 0);
        chk("timeout_once", 32'(timeout_count), 1);
        run_phase("paced", 6'h3F, 1000, 2, 0, 0);
        chk("paced_len1000", actual_frame_cycles, 1000);

        // Power glitch during WAIT_DONE of motor 4.
        motor_mask   = 6'h3F;
        frame_period = 32'd0;
        for (int j = 0; j < 5; j++) begin
            exp_q.push_back(j);
            d_q.push_back(10);
        end
        enable    = 1'b1;
        busy_from = cyc + 1;
        busy_to   = 32'h7FFF_FFFF;
        wait_start("glitch", 4);
        s = cyc;
        tick();
        tick();
        power_sense_n = 1'b1;
        resp_cycle    = -1;
        lat_cycle     = -1;
        ge            = s + 2;
        busy_to       = s + 3;
        tick();
        power_sense_n = 1'b0;
        for (int j = 0; j < 6; j++) begin
            exp_q.push_back(j);
            d_q.push_back(10);
        end
        busy_from = s + 8;
        busy_to   = s + 87;
        while (cyc < s + 9) tick();
        chk("glitch_restart_cycle", 32'(gs), 32'(s + 9));
        while (cyc < s + 87) tick();
        enable = 1'b0;
        tick();
        tick();
        exp_frames += 1;
        exp_actual  = 80;
        end_checks("glitch");

        // Enable dropped during WAIT_DONE of motor 1.
        exp_q.push_back(0); d_q.push_back(10);
        exp_q.push_back(1); d_q.push_back(10);
        enable    = 1'b1;
        busy_from = cyc + 1;
        busy_to   = 32'h7FFF_FFFF;
        wait_start("endrop", 1);
        s = cyc;
        tick();
        enable  = 1'b0;
        busy_to = s + 12;
        while (cyc < s + 16) tick();
        end_checks("endrop");

        // Randomized phases.
        for (int p = 0; p < 6; p++) begin
            rmask = 6'($urandom_range(1, 63));
            rper  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(20, 300)) : 0;
            run_phase("random", rmask, rper, int'($urandom_range(1, 3)), 1, 0);
        end

        // Reset mid-transaction, then requalify power and run one frame.
        exp_q.delete();
        d_q.delete();
        for (int j = 0; j < 6; j++) begin
            exp_q.push_back(j);
            d_q.push_back(10);
        end
        motor_mask   = 6'h3F;
        frame_period = 32'd0;
        enable       = 1'b1;
        busy_from    = cyc + 1;
        busy_to      = 32'h7FFF_FFFF;
        wait_start("midrst", 2);
        tick();
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_gates", 32'(ss_gate_n), 32'h3F);
        chk("midrst_frame_count", frame_count, 0);
        chk("midrst_timeout_count", 32'(timeout_count), 0);
        chk("midrst_actual", actual_frame_cycles, 0);
        exp_q.delete();
        d_q.delete();
        enable       = 1'b0;
        ge           = -1;
        lat_cycle    = -1;
        resp_cycle   = -1;
        busy_to      = -1;
        exp_frames   = 0;
        exp_timeouts = 0;
        exp_actual   = 0;
        tick();
        tick();
        reset = 1'b0;
        run_phase("after_rst", 6'h3F, 0, 1, 0, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
